// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared defines for the integer execute stage.
//   alu_sel_e : ALU selection codes used by the single-cycle ALU.
//   func3_e   : M-extension op codes (instruction func3 field).
//   state_e   : muldiv_unit FSM state encoding.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5,
    ALU_SLL = 3'd6,
    ALU_SRL = 3'd7
  } alu_sel_e;

  typedef enum logic [2:0] {
    F3_MUL    = 3'd0,
    F3_MULH   = 3'd1,
    F3_MULHSU = 3'd2,
    F3_MULHU  = 3'd3,
    F3_DIV    = 3'd4,
    F3_DIVU   = 3'd5,
    F3_REM    = 3'd6,
    F3_REMU   = 3'd7
  } func3_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Upper half of the func3 space is the divide/remainder group.
  function automatic logic is_div(input func3_e f);
    return f[2];
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if -- request/response bus of the multiply/divide unit.
//   in_valid/in_ready   : request handshake, with func3, op_a, op_b
//   out_valid/out_ready : response handshake, with result
//   busy                : unit is not idle (pipeline stall)
// master = requester (pipeline), slave = muldiv_unit.
interface muldiv_if #(
  parameter int unsigned XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      func3;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output in_valid, func3, op_a, op_b, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  in_valid, func3, op_a, op_b, out_ready,
    output in_ready, out_valid, result, busy
  );
endinterface

// File: rtl/muldiv_core.sv
// muldiv_core -- iterative unsigned datapath, one bit per step.
//   load     : capture mag_a/mag_b/div_mode, accumulator = {0, mag_a}
//   step     : advance one shift-add (multiply) or restoring
//              shift-subtract (divide) iteration
//   acc      : multiply -> 2*XLEN product
//              divide   -> {remainder, quotient}
module muldiv_core #(
  parameter int unsigned XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic              div_mode,
  input  logic [XLEN-1:0]   mag_a,
  input  logic [XLEN-1:0]   mag_b,
  output logic [2*XLEN-1:0] acc
);

  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   opb_q;
  logic              mode_q;
  logic [XLEN:0]     sum, rem_sh, diff;

  always_comb begin
    // Multiply: LSB-first, partial sum enters the upper half with its carry.
    sum    = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, opb_q};
    // Divide: partial remainder shifted left with the next dividend bit.
    rem_sh = acc_q[2*XLEN-1:XLEN-1];
    diff   = rem_sh - {1'b0, opb_q};
    acc_d  = acc_q;
    if (mode_q) begin
      // rem_sh < 2*divisor, so diff's top bit is a clean borrow flag.
      if (!diff[XLEN]) acc_d = {diff[XLEN-1:0],   acc_q[XLEN-2:0], 1'b1};
      else             acc_d = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end else begin
      if (acc_q[0]) acc_d = {sum, acc_q[XLEN-1:1]};
      else          acc_d = {1'b0, acc_q[2*XLEN-1:1]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q  <= '0;
      opb_q  <= '0;
      mode_q <= 1'b0;
    end else if (load) begin
      acc_q  <= {{XLEN{1'b0}}, mag_a};
      opb_q  <= mag_b;
      mode_q <= div_mode;
    end else if (step) begin
      acc_q  <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative RV M-extension multiply/divide unit.
//   clk, rst_n : clock, asynchronous active-low reset
//   flush      : abort current operation, return to IDLE
//   bus        : muldiv_if.slave (in_valid/in_ready/func3/op_a/op_b,
//                out_valid/out_ready/result, busy)
// Operands are reduced to magnitudes on accept, muldiv_core runs XLEN
// steps in CALC, FIX applies the sign, DONE holds the result.
// Divide-by-zero and signed overflow skip straight to DONE.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  muldiv_if.slave  bus
);

  localparam int unsigned CW = $clog2(XLEN) + 1;

  state_e            state_q, state_d;
  func3_e            f3_in, op_q;
  logic [CW-1:0]     cnt_q;
  logic              neg_q, neg_d;
  logic [XLEN-1:0]   result_q;

  logic              accept, a_signed, b_signed, a_neg, b_neg;
  logic              div_zero, div_ovf, special;
  logic [XLEN-1:0]   mag_a, mag_b, special_res, quo_fix, rem_fix, fix_res;
  logic [2*XLEN-1:0] acc, prod_fix;

  // Request decode: signedness, magnitudes, result sign, special cases.
  always_comb begin
    f3_in    = func3_e'(bus.func3);
    accept   = bus.in_valid && (state_q == ST_IDLE) && !flush;
    a_signed = f3_in inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
    b_signed = f3_in inside {F3_MULH, F3_DIV, F3_REM};
    a_neg    = a_signed && bus.op_a[XLEN-1];
    b_neg    = b_signed && bus.op_b[XLEN-1];
    mag_a    = a_neg ? -bus.op_a : bus.op_a;
    mag_b    = b_neg ? -bus.op_b : bus.op_b;
    // Remainder follows the dividend; everything else is a xor b.
    neg_d    = (f3_in == F3_REM) ? a_neg : (a_neg ^ b_neg);
    div_zero = is_div(f3_in) && (bus.op_b == '0);
    div_ovf  = (f3_in inside {F3_DIV, F3_REM}) &&
               (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == '1);
    special  = div_zero || div_ovf;
    special_res = '0;
    case (f3_in)
      F3_DIV, F3_DIVU: special_res = div_zero ? '1 : bus.op_a;
      F3_REM, F3_REMU: special_res = div_zero ? bus.op_a : '0;
      default:         special_res = '0;
    endcase
  end

  // Sign correction applied in FIX.
  always_comb begin
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[XLEN-1:0]      : acc[XLEN-1:0];
    rem_fix  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    fix_res  = '0;
    case (op_q)
      F3_MUL:                         fix_res = prod_fix[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU:   fix_res = prod_fix[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:                fix_res = quo_fix;
      F3_REM, F3_REMU:                fix_res = rem_fix;
      default:                        fix_res = '0;
    endcase
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (accept),
    .step     (state_q == ST_CALC),
    .div_mode (is_div(f3_in)),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .acc      (acc)
  );

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state (flush wins over accept and out_ready)
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = special ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_q == CW'(XLEN - 1)) state_d = ST_FIX;
        ST_FIX:  state_d = ST_DONE;
        ST_DONE: if (bus.out_ready) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.in_ready  = (state_q == ST_IDLE);
    bus.busy      = (state_q != ST_IDLE);
    bus.out_valid = (state_q == ST_DONE);
    bus.result    = result_q;
  end

  // Operation context, step counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= F3_MUL;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
    end else if (flush) begin
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q  <= f3_in;
        neg_q <= neg_d;
        cnt_q <= '0;
        if (special) result_q <= special_res;
      end else if (state_q == ST_CALC) begin
        cnt_q <= cnt_q + CW'(1);
      end
      if (state_q == ST_FIX) result_q <= fix_res;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;

  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  int errors = 0;
  int checks = 0;

  muldiv_if #(.XLEN(XLEN)) bus ();

  muldiv_unit #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Reference: RV M-extension semantics from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint     sa, sb;
    logic [63:0] p;
    int         ia, ib;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ia = $signed(a);
    ib = $signed(b);
    case (f)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * longint'({32'b0, b})); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return XLEN + 2;
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // Called just after a falling edge; returns just after a falling edge.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_res,
                        input int exp_lat, input int stall);
    int n;
    bit busy_drop;
    check({tag, "_in_ready"}, bus.in_ready, 1);
    bus.in_valid = 1'b1;
    bus.func3    = f;
    bus.op_a     = a;
    bus.op_b     = b;
    @(negedge clk);
    bus.in_valid = 1'b0;
    n = 1;
    busy_drop = 0;
    while (!bus.out_valid && n < 200) begin
      if (!bus.busy) busy_drop = 1;
      @(negedge clk);
      n++;
    end
    if (!bus.out_valid) begin
      check({tag, "_timeout"}, 0, 1);
      return;
    end
    check({tag, "_latency"}, 64'(n), 64'(exp_lat));
    check({tag, "_result"}, bus.result, exp_res);
    check({tag, "_busy_throughout"}, busy_drop, 0);
    check({tag, "_done_in_ready"}, bus.in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check({tag, "_stall_valid"}, bus.out_valid, 1);
      check({tag, "_stall_result"}, bus.result, exp_res);
      check({tag, "_stall_in_ready"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_released"}, {bus.out_valid, bus.in_ready, bus.busy}, 3'b010);
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  f;
    logic [31:0] a, b, exp;
    int          lat;
    int          stall;
  } vec_t;

  vec_t vecs[$];

  initial begin
    int seen_valid;
    logic [2:0]  f;
    logic [31:0] a, b;

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.func3     = '0;
    bus.op_a      = '0;
    bus.op_b      = '0;

    repeat (3) @(negedge clk);
    check("reset_outputs", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("reset_result", bus.result, 0);
    rst_n = 1'b1;

    // Directed vectors; expectations are fixed constants.
    vecs.push_back('{"mul_7_m3",    3'd0, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, 5});
    vecs.push_back('{"mulh_min",    3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, 0});
    vecs.push_back('{"mulhu_ones",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, 0});
    vecs.push_back('{"mulhsu_ones", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, 0});
    vecs.push_back('{"div_m7_2",    3'd4, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, 0});
    vecs.push_back('{"rem_m7_2",    3'd6, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, 0});
    vecs.push_back('{"divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,        34, 0});
    vecs.push_back('{"remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,         34, 0});
    vecs.push_back('{"divu_by0",    3'd5, 32'd5,        32'd0,        32'hFFFF_FFFF, 1,  0});
    vecs.push_back('{"rem_by0",     3'd6, 32'd5,        32'd0,        32'd5,         1,  0});
    vecs.push_back('{"div_ovf",     3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0});
    vecs.push_back('{"rem_ovf",     3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        1,  0});

    // First request issued on the first rising edge after reset release.
    foreach (vecs[i])
      run_op(vecs[i].tag, vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].stall);

    // Randomized against the model.
    for (int i = 0; i < 80; i++) begin
      f = 3'($urandom_range(0, 7));
      a = rnd_operand();
      b = rnd_operand();
      run_op("rand", f, a, b, model(f, a, b), model_lat(f, a, b), 0);
    end

    // Flush together with a request in IDLE: nothing accepted.
    bus.in_valid = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd4;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_blocks_accept", {bus.in_ready, bus.busy}, 2'b10);

    // Flush at CALC cycle 10.
    bus.in_valid = 1'b1; bus.func3 = 3'd5; bus.op_a = 32'd1000; bus.op_b = 32'd3;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_pre_busy", bus.busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_idle", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    seen_valid = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.out_valid) seen_valid++;
    end
    check("flush_no_valid", 64'(seen_valid), 0);
    run_op("after_flush", 3'd5, 32'd1000, 32'd3, 32'd333, 34, 0);

    // Asynchronous reset in the middle of CALC.
    bus.in_valid = 1'b1; bus.func3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_outputs", {bus.in_ready, bus.out_valid, bus.busy}, 3'b100);
    check("arst_result", bus.result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_reset", 3'd1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 34, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
